cla_pipe_addsub: RTL and testbench

CLA_PIPE_ADDSUB -- requirements
Module: cla_pipe_addsub

---
 rtl/cla_pipe_addsub.sv | 115 +++++++++++
 tb/tb_cla_pipe_addsub.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined add/subtract, one carry-lookahead segment per stage.
module cla_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int NSEG = WIDTH / SEG_WIDTH;
  localparam int NG = SEG_WIDTH / 4;
  localparam int L = NSEG - 1;
  if (WIDTH % SEG_WIDTH != 0 || SEG_WIDTH % 4 != 0 || NSEG < 1) begin : g_bad
    $error("cla_pipe_addsub: WIDTH must be a multiple of SEG_WIDTH and SEG_WIDTH a multiple of 4");
  end
  // carry into position n as a flat sum of products of generate/propagate terms
  function automatic logic look(input logic [SEG_WIDTH-1:0] g, p, input logic c0, input int n);
    logic r, t;
    r = c0;
    for (int i = 0; i < n; i++) r &= p[i];
    for (int i = 0; i < n; i++) begin
      t = g[i];
      for (int j = i + 1; j < n; j++) t &= p[j];
      r |= t;
    end
    return r;
  endfunction
  logic adv;
  assign adv = out_ready | ~out_valid;
  assign in_ready = adv;
  for (genvar s = 0; s < NSEG; s++) begin : g_st
    logic [WIDTH-1:s*SEG_WIDTH] ai, bi;
    logic ci, pv, v, c_q;
    logic [SEG_WIDTH-1:0] p, g, ss;
    logic [SEG_WIDTH:0] bc;
    logic [NG-1:0] gg, gp;
    logic [(s+1)*SEG_WIDTH-1:0] sn, s_q;
    if (s == 0) begin : g_in
      assign ai = a;
      assign bi = b ^ {WIDTH{op}};
      assign ci = cin ^ op;
      assign pv = in_valid;
      assign sn = ss;
    end else begin : g_in
      assign ai = g_st[s-1].g_fw.a_q;
      assign bi = g_st[s-1].g_fw.b_q;
      assign ci = g_st[s-1].c_q;
      assign pv = g_st[s-1].v;
      assign sn = {ss, g_st[s-1].s_q};
    end
    assign p = ai[s*SEG_WIDTH +: SEG_WIDTH] ^ bi[s*SEG_WIDTH +: SEG_WIDTH];
    assign g = ai[s*SEG_WIDTH +: SEG_WIDTH] & bi[s*SEG_WIDTH +: SEG_WIDTH];
    always_comb begin
      bc = '0;
      gg = '0;
      gp = '0;
      for (int j = 0; j < NG; j++) begin
        gp[j] = &p[4*j +: 4];
        gg[j] = look(SEG_WIDTH'(g[4*j +: 4]), SEG_WIDTH'(p[4*j +: 4]), 1'b0, 4);
      end
      for (int j = 0; j <= NG; j++) bc[4*j] = look(SEG_WIDTH'(gg), SEG_WIDTH'(gp), ci, j);
      for (int j = 0; j < NG; j++)
        for (int k = 1; k < 4; k++)
          bc[4*j+k] = look(SEG_WIDTH'(g[4*j +: 4]), SEG_WIDTH'(p[4*j +: 4]), bc[4*j], k);
    end
    assign ss = p ^ bc[SEG_WIDTH-1:0];
    always_ff @(posedge clk)
      if (rst) begin
        v <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v <= pv;
        c_q <= bc[SEG_WIDTH];
        s_q <= sn;
      end
    if (s < L) begin : g_fw
      logic [WIDTH-1:(s+1)*SEG_WIDTH] a_q, b_q;
      always_ff @(posedge clk)
        if (adv) begin
          a_q <= ai[WIDTH-1:(s+1)*SEG_WIDTH];
          b_q <= bi[WIDTH-1:(s+1)*SEG_WIDTH];
        end
    end
    if (s == L) begin : g_fl
      logic o_q, z_q;
      always_ff @(posedge clk)
        if (rst) begin
          o_q <= 1'b0;
          z_q <= 1'b0;
        end else if (adv) begin
          o_q <= bc[SEG_WIDTH-1] ^ bc[SEG_WIDTH];
          z_q <= ~|sn;
        end
    end
  end
  assign out_valid = g_st[L].v;
  assign sum = g_st[L].s_q;
  assign cout = g_st[L].c_q;
  assign ovf = g_st[L].g_fl.o_q;
  assign zero = g_st[L].g_fl.z_q;
  assign neg = sum[WIDTH-1];
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb_cla_pipe_addsub: scoreboard bench driving 32/16, 32/8 and 64/64 adders from one stimulus stream.
module tb_cla_pipe_addsub;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, cin, op;
  logic [63:0] a64, b64;
  wire [2:0] ov, ir, co, of, ze, ng;
  wire [31:0] s0, s1;
  wire [63:0] s2;
  logic [67:0] res [3];
  logic [67:0] hres [3];
  logic [67:0] q [3][$];
  bit held [3];
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  cla_pipe_addsub #(.WIDTH(32), .SEG_WIDTH(16)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a64[31:0]), .b(b64[31:0]),
    .cin(cin), .op(op), .out_valid(ov[0]), .out_ready(out_ready), .sum(s0), .cout(co[0]),
    .ovf(of[0]), .zero(ze[0]), .neg(ng[0]));
  cla_pipe_addsub #(.WIDTH(32), .SEG_WIDTH(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a64[31:0]), .b(b64[31:0]),
    .cin(cin), .op(op), .out_valid(ov[1]), .out_ready(out_ready), .sum(s1), .cout(co[1]),
    .ovf(of[1]), .zero(ze[1]), .neg(ng[1]));
  cla_pipe_addsub #(.WIDTH(64), .SEG_WIDTH(64)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a64), .b(b64),
    .cin(cin), .op(op), .out_valid(ov[2]), .out_ready(out_ready), .sum(s2), .cout(co[2]),
    .ovf(of[2]), .zero(ze[2]), .neg(ng[2]));
  assign res[0] = {32'b0, s0, co[0], of[0], ze[0], ng[0]};
  assign res[1] = {32'b0, s1, co[1], of[1], ze[1], ng[1]};
  assign res[2] = {s2, co[2], of[2], ze[2], ng[2]};
  task automatic chk(input bit ok, input string name, input logic [67:0] act, input logic [67:0] exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // arithmetic reference: exact integer result, then wrap, borrow and signed-range checks
  function automatic logic [67:0] model(input logic [63:0] x, y, input logic ci, o, input int w);
    logic signed [67:0] m, ux, uy, sx, sy, ur, sr, c;
    logic [63:0] s;
    m = 68'sd1 <<< w;
    c = $signed({67'b0, ci});
    ux = $signed({4'b0, x});
    uy = $signed({4'b0, y});
    sx = x[w-1] ? ux - m : ux;
    sy = y[w-1] ? uy - m : uy;
    ur = o ? ux - uy - c : ux + uy + c;
    sr = o ? sx - sy - c : sx + sy + c;
    s = 64'(ur & (m - 68'sd1));
    return {s, o ? ur >= 0 : ur >= m, sr >= (m >>> 1) || sr < -(m >>> 1), s == 64'b0, s[w-1]};
  endfunction
  function automatic logic [63:0] pick();
    int r;
    r = $urandom_range(0, 7);
    return r == 0 ? 64'b0 : r == 1 ? '1 : r == 2 ? {2{32'h7fffffff}} : r == 3 ? {2{32'h80000000}}
         : {$urandom, $urandom};
  endfunction
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) q[k].delete();
      else begin
        if (held[k]) chk(res[k] == hres[k], $sformatf("hold%0d", k), res[k], hres[k]);
        if (ov[k] && out_ready) begin
          if (q[k].size() == 0) chk(1'b0, $sformatf("spurious%0d", k), res[k], 68'b0);
          else begin
            logic [67:0] e;
            e = q[k].pop_front();
            chk(res[k] == e, $sformatf("result%0d", k), res[k], e);
          end
        end
        if (in_valid && ir[k])
          q[k].push_back(model(k == 2 ? a64 : {32'b0, a64[31:0]}, k == 2 ? b64 : {32'b0, b64[31:0]},
                               cin, op, k == 2 ? 64 : 32));
      end
      held[k] = ov[k] && !out_ready && !rst;
      hres[k] = res[k];
    end
  end
  task automatic direct(input logic [31:0] x, y, input logic ci, o, input logic [35:0] e);
    @(posedge clk);
    #1;
    a64 = {32'b0, x};
    b64 = {32'b0, y};
    cin = ci;
    op = o;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk(!ov[0], "latency_early", 68'(ov[0]), 68'b0);
    @(negedge clk);
    chk(ov[0] && res[0][35:0] == e, "directed", {ov[0], res[0][66:0]}, {32'b1, e});
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [35:0] e0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a64 = '0;
    b64 = '0;
    cin = 1'b0;
    op = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(ov == 3'b0, "reset_valid", 68'(ov), 68'b0);
    chk(res[0] == 68'b0 && res[1] == 68'b0 && res[2] == 68'b0, "reset_outputs", res[2] | res[0], 68'b0);
    chk(ir == 3'b111, "reset_ready", 68'(ir), 68'h7);
    @(posedge clk);
    #1 rst = 1'b0;
    direct(32'h0000ffff, 32'h1, 1'b0, 1'b0, {32'h00010000, 4'b0000});
    direct(32'd5, 32'd5, 1'b0, 1'b1, {32'h0, 4'b1010});
    direct(32'd0, 32'd1, 1'b0, 1'b1, {32'hffffffff, 4'b0001});
    direct(32'h7fffffff, 32'h1, 1'b0, 1'b0, {32'h80000000, 4'b0101});
    direct(32'hffffffff, 32'h1, 1'b0, 1'b0, {32'h0, 4'b1010});
    direct(32'd10, 32'd3, 1'b1, 1'b1, {32'd6, 4'b1000});
    direct(32'h0000ffff, 32'h0, 1'b1, 1'b0, {32'h00010000, 4'b0000});
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int t;
          @(posedge clk);
          #1;
          a64 = {$urandom, $urandom};
          b64 = {$urandom, $urandom};
          cin = 1'($urandom_range(0, 1));
          op = 1'($urandom_range(0, 1));
          in_valid = 1'b1;
          if (i == 0) e0 = model({32'b0, a64[31:0]}, {32'b0, b64[31:0]}, cin, op, 32)[35:0];
          t = 0;
          @(negedge clk);
          while (!ir[0] && t < 20) begin
            @(negedge clk);
            t++;
          end
          chk(t < 20, "accept_timeout", 68'(t), 68'd20);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk(!ir[0] && ov[0], "stall_full", {66'b0, ir[0], ov[0]}, 68'b01);
          chk(res[0][35:0] == e0, "stall_hold", res[0], 68'(e0));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    a64 = 64'h5;
    b64 = 64'h7;
    op = 1'b0;
    cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk(!ov[0], "reset_flush", 68'(ov[0]), 68'b0);
    end
    direct(32'h12345678, 32'h11111111, 1'b0, 1'b0, {32'h23456789, 4'b0000});
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      a64 = pick();
      b64 = pick();
      cin = 1'($urandom_range(0, 1));
      op = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk(q[k].size() == 0, $sformatf("drain%0d", k), 68'(q[k].size()), 68'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
